// File: rtl/mem.sv
// Simple dual-address RAM: one unconditional write port and one registered read port.
// The read register resets asynchronously. The storage array is never cleared.
module mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    write_addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic [AW-1:0]    read_addr,
  output logic [WIDTH-1:0] read_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_q;
  logic [WIDTH-1:0] rd_d;
  logic             wr_ok;
  logic             rd_ok;

  // Range checks are only needed when DEPTH leaves unused address codes.
  if (DEPTH == (1 << AW)) begin : g_pow2
    assign wr_ok = 1'b1;
    assign rd_ok = 1'b1;
  end else begin : g_npow2
    localparam logic [AW:0] LIMIT = DEPTH[AW:0];
    assign wr_ok = {1'b0, write_addr} < LIMIT;
    assign rd_ok = {1'b0, read_addr} < LIMIT;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem_q[write_addr] <= write_data;
    end
  end

  always_comb begin
    rd_d = '0;
    if (rd_ok) begin
      rd_d = mem_q[read_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign read_data = rd_q;

endmodule

// File: tb/tb_mem.sv
// Directed bench for mem: basic access, read-before-write, reset,
// address sweep and write suppression while in reset.
module tb_mem;

  localparam int WIDTH = 32;
  localparam int DEPTH = 256;
  localparam int AW = 8;

  logic             clk;
  logic             rst;
  logic [AW-1:0]    write_addr;
  logic [WIDTH-1:0] write_data;
  logic [AW-1:0]    read_addr;
  logic [WIDTH-1:0] read_data;

  int compared;
  int mismatched;

  mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .write_addr(write_addr),
    .write_data(write_data),
    .read_addr(read_addr),
    .read_data(read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] exp);
    compared++;
    assert (read_data === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, read_data, exp);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    write_addr = '0;
    write_data = '0;
    read_addr  = '0;
    tick();
    tick();
    check("reset_state", 32'd0);

    // basic write then read
    write_addr = 8'd4;
    write_data = 32'd42;
    read_addr  = 8'd0;
    rst        = 1'b0;
    tick();
    read_addr = 8'd4;
    tick();
    check("basic_read", 32'd42);
    #3;
    check("hold_between_edges", 32'd42);

    // same-address read-before-write
    @(posedge clk);
    #1;
    write_data = 32'd31;
    tick();
    check("rbw_old", 32'd42);
    tick();
    check("rbw_new", 32'd31);

    // async reset, then simultaneous write/read of addr 4
    rst = 1'b1;
    #2;
    check("async_reset", 32'd0);
    write_addr = 8'd4;
    write_data = 32'd42;
    read_addr  = 8'd4;
    rst        = 1'b0;
    tick();
    check("simul_old", 32'd31);
    tick();
    check("simul_new", 32'd42);

    // contents survive reset
    write_addr = 8'd200;
    write_data = 32'd0;
    read_addr  = 8'd0;
    tick();
    rst = 1'b1;
    #2;
    check("async_reset2", 32'd0);
    rst       = 1'b0;
    read_addr = 8'd4;
    tick();
    check("retained", 32'd42);

    // full address sweep
    for (int i = 0; i < DEPTH; i++) begin
      write_addr = AW'(i);
      write_data = WIDTH'(i * 3 + 1);
      tick();
    end
    write_addr = 8'd255;
    write_data = 32'd766;
    for (int i = 0; i < DEPTH; i++) begin
      read_addr = AW'(i);
      tick();
      check($sformatf("sweep_%0d", i), WIDTH'(i * 3 + 1));
    end

    // writes suppressed while rst is high
    rst        = 1'b1;
    write_addr = 8'd7;
    write_data = 32'd99;
    read_addr  = 8'd7;
    tick();
    check("rst_hold1", 32'd0);
    tick();
    check("rst_hold2", 32'd0);
    write_addr = 8'd255;
    write_data = 32'd766;
    rst        = 1'b0;
    tick();
    check("no_write_in_rst", 32'd22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem.md
Name: mem

Overview:
- Single-port-write, single-port-read synchronous RAM with a registered read output.
- Writes occur on every rising clock edge; there is no write enable.
- Used as a generic storage primitive, e.g. register files or lookup buffers.
- One clock domain; asynchronous active-high reset clears only the read register, not the array.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- DEPTH, 256, number of words (>=2); address width AW = $clog2(DEPTH), i.e. 8 at default.

Ports:
- clk  input  1  clock; all array and read-register updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high; the port is named rst.
- write_addr  input  AW  word address written at each rising edge.
- write_data  input  WIDTH  data stored at write_addr.
- read_addr  input  AW  word address sampled at each rising edge.
- read_data  output  WIDTH  registered read result.

Behaviour:
- Storage: array of DEPTH words of WIDTH bits. Contents are not initialised and not cleared by rst.
  - Unwritten words read as X in simulation.
- Write:
  - At each rising clk with rst low: mem[write_addr] <= write_data, unconditionally.
  - Every cycle out of reset writes; hold write_addr/write_data stable to "idle" on a harmless location.
- Write suppression: while rst is high, no write occurs, and the array keeps its contents.
- Read:
  - At each rising clk with rst low: read_data <= mem[read_addr].
  - Latency is 1 cycle from read_addr presentation to read_data valid.
  - read_data holds its value between edges.
- Simultaneous read and write, same address, same edge: read-before-write.
  - read_data gets the OLD contents.
  - The new data is visible on the next edge if read_addr is still held.
- Different addresses on the same edge: independent, no interaction.
- Reset:
  - rst asserted forces read_data to 0 immediately (asynchronous).
  - read_data stays 0 while rst is high.
  - The first post-reset edge with rst low performs a normal read and write.
- Reset mid-operation:
  - A write on the same edge that rst rises is discarded.
  - Previously written words survive reset.
- Out of range (DEPTH not a power of 2):
  - A write to an address >= DEPTH is ignored.
  - A read from an address >= DEPTH returns 0.
- Implementation target:
  - Inferable as block RAM: one write port and one synchronous read port.
  - No combinational path from inputs to read_data.

Test Plan:
- Basic write/read (default params):
  - Reset; write_addr=4, write_data=42; tick.
  - read_addr=4; tick -> read_data=42.
- Read-before-write:
  - With read_addr=4 and write_addr=4, set write_data=31; tick -> read_data=42 (old).
  - Tick -> read_data=31.
- Simultaneous write/read of a fresh location:
  - Reset; write_addr=4, write_data=42, read_addr=4; tick -> read_data = prior mem[4] (31 if previous test ran, else X).
  - Tick -> read_data=42.
- Reset behaviour:
  - Drive rst high between clock edges -> read_data=0 without a clock edge.
  - Release rst, read_addr=4, tick -> read_data = value stored before reset (contents retained).
- Address sweep:
  - Write addr i with data i*3+1 for i=0..255.
  - Read back all addresses -> each matches, with 1-cycle latency.
  - Addresses 0 and 255 wrap-free.
- Write suppression in reset:
  - Hold rst high, write_addr=7, write_data=99, tick twice; release rst.
  - read_addr=7 -> read_data != 99 (unchanged prior value).
